// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: operand width,
// controller states, magnitude helper and the active-low 7-segment table.
package div_pkg;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned CNT_W = $clog2(WIDTH);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREP,
      ST_ITER,
      ST_FIX,
      ST_HOLD
   } state_t;

   // Segment order {g,f,e,d,c,b,a}, active-low; entry 0 is the rightmost.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   // Two's-complement magnitude; the most negative value maps to itself,
   // which reads correctly as an unsigned magnitude.
   function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
      return x[WIDTH-1] ? WIDTH'(-x) : x;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step on unsigned magnitudes.
// Ports: r_in/q_in/d_in current remainder, quotient shift register, divisor;
//        r_out/q_out values after shifting in one quotient bit.
module div_step
   import div_pkg::*;
(
   input  logic [WIDTH:0]   r_in,
   input  logic [WIDTH-1:0] q_in,
   input  logic [WIDTH-1:0] d_in,
   output logic [WIDTH:0]   r_out,
   output logic [WIDTH-1:0] q_out
);

   // One guard bit above the shifted remainder gives the trial sign.
   logic [WIDTH+1:0] r_shift;
   logic [WIDTH+1:0] trial;

   always_comb begin
      r_shift = {r_in, q_in[WIDTH-1]};
      trial   = r_shift - {2'b00, d_in};
      if (!trial[WIDTH+1]) begin
         r_out = trial[WIDTH:0];
         q_out = {q_in[WIDTH-2:0], 1'b1};
      end else begin
         r_out = r_shift[WIDTH:0];
         q_out = {q_in[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/hex_driver.sv
// Nibble to active-low 7-segment decoder.
// Ports: nibble value in; seg_n segments {g,f,e,d,c,b,a}, low = lit.
module hex_driver
   import div_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_n
);

   assign seg_n = SEG_TABLE[nibble];

endmodule

// File: rtl/seq_divider.sv
// Sequential 8-bit signed restoring divider with switch/button operation.
// Ports: CLK, RESET (async active-low), RUN/CLEARA_LOADB active-low buttons,
//        S switches (dividend on load, divisor on run); QVAL/RVAL quotient
//        and remainder registers, DONE/DZ/OVF status, four hex displays.
module seq_divider
   import div_pkg::*;
(
   input  logic             CLK,
   input  logic             RESET,
   input  logic             RUN,
   input  logic             CLEARA_LOADB,
   input  logic [WIDTH-1:0] S,
   output logic [WIDTH-1:0] QVAL,
   output logic [WIDTH-1:0] RVAL,
   output logic             DONE,
   output logic             DZ,
   output logic             OVF,
   output logic [6:0]       QHEXU,
   output logic [6:0]       QHEXL,
   output logic [6:0]       RHEXU,
   output logic [6:0]       RHEXL
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic [WIDTH:0]     r_q, r_d;
   logic [WIDTH-1:0]   d_q, d_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               sq_q, sq_d;
   logic               sd_q, sd_d;
   logic               done_q, done_d;
   logic               dz_q, dz_d;
   logic               ovf_q, ovf_d;

   logic [WIDTH:0]     step_r;
   logic [WIDTH-1:0]   step_q;

   div_step u_step (
      .r_in  (r_q),
      .q_in  (q_q),
      .d_in  (d_q),
      .r_out (step_r),
      .q_out (step_q)
   );

   // State and datapath registers.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= ST_IDLE;
         q_q     <= '0;
         r_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         sq_q    <= 1'b0;
         sd_q    <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         r_q     <= r_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         sq_q    <= sq_d;
         sd_q    <= sd_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
         ovf_q   <= ovf_d;
      end
   end

   // Controller: next state and datapath updates.
   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      r_d     = r_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      sq_d    = sq_q;
      sd_d    = sd_q;
      dz_d    = dz_q;
      ovf_d   = ovf_q;

      unique case (state_q)
         ST_IDLE: begin
            if (!CLEARA_LOADB) begin
               q_d   = S;
               r_d   = '0;
               dz_d  = 1'b0;
               ovf_d = 1'b0;
            end else if (!RUN) begin
               d_d     = S;
               state_d = ST_PREP;
            end
         end
         ST_PREP: begin
            sq_d  = q_q[WIDTH-1];
            sd_d  = d_q[WIDTH-1];
            cnt_d = '0;
            if (d_q == '0) begin
               dz_d    = 1'b1;
               q_d     = '1;
               r_d     = {1'b0, q_q};
               state_d = ST_HOLD;
            end else begin
               q_d     = abs_val(q_q);
               d_d     = abs_val(d_q);
               r_d     = '0;
               state_d = ST_ITER;
            end
         end
         ST_ITER: begin
            q_d   = step_q;
            r_d   = step_r;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            if (sq_q ^ sd_q) begin
               q_d = WIDTH'(-q_q);
            end
            if (sq_q) begin
               r_d = (WIDTH + 1)'(-r_q);
            end
            // Only -128 / -1 yields a positive magnitude of 128.
            ovf_d   = (q_q == {1'b1, {(WIDTH - 1){1'b0}}}) && (sq_q == sd_q);
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (RUN) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      done_d = (state_d == ST_HOLD);
   end

   assign QVAL = q_q;
   assign RVAL = r_q[WIDTH-1:0];
   assign DONE = done_q;
   assign DZ   = dz_q;
   assign OVF  = ovf_q;

   hex_driver u_qhexu (.nibble(q_q[7:4]), .seg_n(QHEXU));
   hex_driver u_qhexl (.nibble(q_q[3:0]), .seg_n(QHEXL));
   hex_driver u_rhexu (.nibble(r_q[7:4]), .seg_n(RHEXU));
   hex_driver u_rhexl (.nibble(r_q[3:0]), .seg_n(RHEXL));

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expected results are queued when a run
// is started and compared when DONE is seen.
module tb_seq_divider;

   logic       CLK;
   logic       RESET;
   logic       RUN;
   logic       CLEARA_LOADB;
   logic [7:0] S;
   logic [7:0] QVAL;
   logic [7:0] RVAL;
   logic       DONE;
   logic       DZ;
   logic       OVF;
   logic [6:0] QHEXU;
   logic [6:0] QHEXL;
   logic [6:0] RHEXU;
   logic [6:0] RHEXL;

   seq_divider dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .RUN          (RUN),
      .CLEARA_LOADB (CLEARA_LOADB),
      .S            (S),
      .QVAL         (QVAL),
      .RVAL         (RVAL),
      .DONE         (DONE),
      .DZ           (DZ),
      .OVF          (OVF),
      .QHEXU        (QHEXU),
      .QHEXL        (QHEXL),
      .RHEXU        (RHEXU),
      .RHEXL        (RHEXL)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [7:0] q;
      logic [7:0] r;
      logic       dz;
      logic       ovf;
      logic [7:0] lat;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Independent active-low 7-segment reference {g,f,e,d,c,b,a}.
   function automatic logic [6:0] seg(input logic [3:0] n);
      case (n)
         4'h0: return 7'b1000000;
         4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;
         4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;
         4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;
         4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;
         4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;
         4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;
         default: return 7'b0001110;
      endcase
   endfunction

   // Reference: signed truncating division with the board's special cases.
   function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      int   sa;
      int   sb;
      sa = $signed(a);
      sb = $signed(b);
      e  = '0;
      if (sb == 0) begin
         e.q   = 8'hFF;
         e.r   = a;
         e.dz  = 1'b1;
         e.lat = 8'd2;
      end else begin
         e.lat = 8'd11;
         if (sa == -128 && sb == -1) begin
            e.q   = 8'h80;
            e.r   = 8'h00;
            e.ovf = 1'b1;
         end else begin
            e.q = 8'(sa / sb);
            e.r = 8'(sa % sb);
         end
      end
      return e;
   endfunction

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_qval"}, 32'(QVAL), 32'h0);
      chk({tag, "_rval"}, 32'(RVAL), 32'h0);
      chk({tag, "_done"}, 32'(DONE), 32'h0);
      chk({tag, "_dz"}, 32'(DZ), 32'h0);
      chk({tag, "_ovf"}, 32'(OVF), 32'h0);
      chk({tag, "_hex"}, {4'h0, QHEXU, QHEXL, RHEXU, RHEXL},
          {4'h0, seg(4'h0), seg(4'h0), seg(4'h0), seg(4'h0)});
   endtask

   task automatic load(input logic [7:0] a);
      @(negedge CLK);
      S            = a;
      CLEARA_LOADB = 1'b0;
      @(negedge CLK);
      CLEARA_LOADB = 1'b1;
      chk("load_qval", 32'(QVAL), 32'(a));
   endtask

   // Load, start, then wait for DONE; edge 0 is the edge sampling RUN low.
   task automatic run_div(input logic [7:0] a, input logic [7:0] b, input bit keep_run);
      exp_t e;
      int   k;
      load(a);
      S   = b;
      RUN = 1'b0;
      exp_q.push_back(model(a, b));
      @(posedge CLK);
      k = 31;
      for (int i = 1; i <= 30; i++) begin
         @(negedge CLK);
         if (!keep_run) RUN = 1'b1;
         if (DONE) begin
            k = i;
            break;
         end
      end
      e = exp_q.pop_front();
      chk("latency", 32'(k), 32'(e.lat));
      chk("qval", 32'(QVAL), 32'(e.q));
      chk("rval", 32'(RVAL), 32'(e.r));
      chk("dz", 32'(DZ), 32'(e.dz));
      chk("ovf", 32'(OVF), 32'(e.ovf));
      chk("hex", {4'h0, QHEXU, QHEXL, RHEXU, RHEXL},
          {4'h0, seg(e.q[7:4]), seg(e.q[3:0]), seg(e.r[7:4]), seg(e.r[3:0])});
      if (!keep_run) begin
         @(negedge CLK);
         chk("done_clear", 32'(DONE), 32'h0);
      end
   endtask

   localparam int NDIR = 8;
   logic [7:0] dir_a [NDIR] = '{8'h64, 8'h9C, 8'h64, 8'h9C, 8'h25, 8'h80, 8'h80, 8'h7F};
   logic [7:0] dir_b [NDIR] = '{8'h07, 8'h07, 8'hF9, 8'hF9, 8'h00, 8'hFF, 8'h01, 8'h80};

   initial begin
      RESET        = 1'b1;
      RUN          = 1'b1;
      CLEARA_LOADB = 1'b1;
      S            = 8'h00;
      #1 RESET = 1'b0;
      #2;
      check_zero_outputs("reset");
      repeat (2) @(negedge CLK);
      RESET = 1'b1;

      // Directed cases, then random operands.
      for (int i = 0; i < NDIR; i++) run_div(dir_a[i], dir_b[i], 1'b0);
      for (int i = 0; i < 16; i++) run_div(8'($urandom), 8'($urandom), 1'b0);

      // Load has priority over RUN when both are pressed.
      @(negedge CLK);
      S            = 8'h33;
      CLEARA_LOADB = 1'b0;
      RUN          = 1'b0;
      repeat (3) @(negedge CLK);
      CLEARA_LOADB = 1'b1;
      RUN          = 1'b1;
      chk("prio_qval", 32'(QVAL), 32'h33);
      chk("prio_done", 32'(DONE), 32'h0);

      // Reset during the fourth iteration cycle aborts the run.
      load(8'h64);
      S   = 8'h07;
      RUN = 1'b0;
      @(posedge CLK);
      for (int i = 1; i <= 5; i++) begin
         @(negedge CLK);
         RUN = 1'b1;
      end
      RESET = 1'b0;
      #1;
      check_zero_outputs("midreset");
      @(negedge CLK);
      RESET = 1'b1;
      repeat (15) @(negedge CLK);
      check_zero_outputs("no_resume");

      // RUN held low through HOLD must not start a second run.
      run_div(8'h64, 8'h07, 1'b1);
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         chk("hold_done", 32'(DONE), 32'h1);
         chk("hold_qval", 32'(QVAL), 32'h0E);
         chk("hold_rval", 32'(RVAL), 32'h02);
      end
      RUN = 1'b1;
      @(negedge CLK);
      chk("release_done", 32'(DONE), 32'h0);
      run_div(8'h64, 8'h07, 1'b0);

      chk("queue_empty", 32'(exp_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential 8-bit signed two's-complement divider; the inverse-operation companion to the shift-add multiplier on the same lab board.
- Uses the same switch/button operator model: the dividend is loaded from switches S with CLEARA_LOADB, and the divisor is taken from S at RUN.
- Restoring division, one quotient bit per clock.
- Quotient and remainder are shown live on two 8-bit buses and four hex displays.

Parameters:
- WIDTH, 8, operand/quotient/remainder width; the bench covers only 8.

Ports:
- CLK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-low; clears all state
- RUN  in  1  active-low start button
- CLEARA_LOADB  in  1  active-low; in IDLE loads dividend from S and clears remainder
- S  in  8  switch operand: dividend at load, divisor at run
- QVAL  out  8  quotient register (dividend while loading, partial quotient during iteration)
- RVAL  out  8  remainder register, low 8 bits
- DONE  out  1  high in HOLD; results final
- DZ  out  1  divide-by-zero flag
- OVF  out  1  overflow flag (-128 / -1)
- QHEXU, QHEXL, RHEXU, RHEXL  out  7 each  active-low segments for QVAL/RVAL nibbles

Behaviour:
- Reset (asynchronous, active-low):
  - State goes to IDLE.
  - Q, R (9-bit), D, iteration count, sign bits, DONE, DZ, OVF all clear to 0.
  - QVAL=RVAL=0; all hex outputs show "0".
- State machine:
  - States: IDLE, PREP, ITER, FIX, HOLD. An enum in the package; the encoding is free.
- IDLE:
  - If CLEARA_LOADB=0: Q<=S, R<=0, DZ<=0, OVF<=0.
  - Else if RUN=0: D<=S, state goes to PREP.
  - CLEARA_LOADB has priority over RUN.
- PREP:
  - Latch sQ=Q[7] and sD=D[7].
  - Q<=|Q| and D<=|D| as unsigned 8-bit values; |0x80| is 0x80.
  - R<=0 and count<=0.
  - If D==0: DZ<=1, Q<=0xFF, R<= original dividend, state goes to HOLD. This path skips ITER and FIX.
  - Otherwise state goes to ITER.
- ITER, one bit per cycle:
  - Shift {R,Q} left by 1.
  - Compute trial = R_shifted - {0,D} (9-bit).
  - If trial[8]==0: R<=trial and Q[0]<=1. Otherwise R<=R_shifted and Q[0]<=0.
  - After 8 cycles (count==7), state goes to FIX.
- FIX:
  - If sQ^sD, Q<=-Q.
  - If sQ, R<=-R.
  - Truncation is toward zero; the remainder takes the dividend's sign.
  - OVF<=1 if the magnitudes quotient was 0x80 and sQ==sD.
  - State goes to HOLD.
- HOLD:
  - DONE=1; Q and R are frozen.
  - State returns to IDLE only when RUN=1. Holding RUN low never re-triggers a run.
- Latency, with the RUN-low sample in IDLE at edge 0:
  - PREP at edge 1, ITER edges 2..9, FIX at edge 10, HOLD/DONE at edge 11.
  - Divide-by-zero reaches DONE at edge 2.
- Ignored inputs: S, RUN and CLEARA_LOADB are ignored outside the states noted above. CLEARA_LOADB is ignored in HOLD.
- Mid-operation reset: asserting RESET in any state aborts at once. The operation is not resumed after release.
- Outputs:
  - QVAL=Q[7:0] and RVAL=R[7:0] at all times. During iteration they show magnitudes, not final values.
  - Hex outputs are combinational from QVAL/RVAL.

Decomposition:
- Package div_pkg holds the state enum, WIDTH, and the 16-entry 7-segment table.
- Sub-module div_step, purely combinational:
  - Inputs: R(9), Q(8), D(8).
  - Outputs: next R, next Q.
- The existing hex driver is reused four times.

Test Plan:
1. Load: CLEARA_LOADB=0 with S=0x64, then RUN=0 with S=0x07 -> DONE rises exactly 11 cycles after the RUN sample; QVAL=0x0E, RVAL=0x02, DZ=OVF=0.
2. Signed dividend: dividend 0x9C (-100), divisor 0x07 -> QVAL=0xF2 (-14), RVAL=0xFE (-2).
3. Signed divisor: dividend 0x64, divisor 0xF9 (-7) -> QVAL=0xF2, RVAL=0x02. Then dividend 0x9C, divisor 0xF9 -> QVAL=0x0E, RVAL=0xFE.
4. Divide by zero: dividend 0x25, divisor 0x00 -> DONE at edge 2, DZ=1, QVAL=0xFF, RVAL=0x25.
5. Overflow: dividend 0x80, divisor 0xFF -> QVAL=0x80, RVAL=0x00, OVF=1. Also dividend 0x80, divisor 0x01 -> QVAL=0x80, OVF=0.
6. Reset and re-run:
   - RESET low during the 4th ITER cycle -> all outputs 0, state IDLE.
   - Hold RUN low through HOLD for 20 cycles -> no second run.
   - Release RUN, then press it again -> a new division completes with the same results as before.
